// File: rtl/key_pio_edge.sv
// key_pio_edge
//   Avalon-MM key/button PIO with per-bit edge capture and a level interrupt.
//   Raw keys go through a 2-flop synchronizer, then an optional per-bit
//   debounce filter, then an edge detector that sets sticky edgecapture bits.
//
//   Optional feature: define KEY_PIO_DEBOUNCE_EN to build the debounce
//   counters. When it is undefined, the filtered value is the synchronizer
//   output and DEBOUNCE_CYCLES has no effect.
//
//   Register map (word address):
//     0 : data        RO  filtered inputs
//     2 : irqmask     RW  WIDTH bits
//     3 : edgecapture RO  write-1-to-clear (a new edge beats a clear)
//     others read 0, writes ignored
//
//   Ports:
//     clk, reset_n           clock (rising edge), async active-low reset
//     address[2:0]           word address
//     chipselect, write_n    write strobe = chipselect & ~write_n
//     writedata[31:0]        write data (bits above WIDTH-1 ignored)
//     in_port[WIDTH-1:0]     raw asynchronous key inputs (idle high)
//     readdata[31:0]         registered read data, one-cycle latency
//     irq                    registered OR of (edgecapture & irqmask)
module key_pio_edge #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    generate
        if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 ||
            DEBOUNCE_CYCLES > (1 << 20) || EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_param
            $error("key_pio_edge: illegal parameter value");
        end
    endgenerate

    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] filt, filt_d;
    logic [WIDTH-1:0] irqmask, edgecapture;
    logic [WIDTH-1:0] hit, clr;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata matter.
    assign unused_wdata = ^writedata;

    // Synchronizer; resets to idle-high so release does not look like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // The filtered bit follows the synchronized bit only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement
    // restarts the count.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
        logic [CW-1:0] cnt;
        logic          filt_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt    <= '0;
                filt_q <= 1'b1;
            end else if (sync2[gi] != filt_q) begin
                if (cnt == CNT_MAX) begin
                    filt_q <= sync2[gi];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end

        assign filt[gi] = filt_q;
    end
`else
    assign filt = sync2;
`endif

    assign wr  = chipselect & ~write_n;
    assign clr = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

    // filt_d holds last cycle's filtered value, so an edge shows up the
    // cycle after filt changes and lands in edgecapture on the next edge.
    always_comb begin
        hit = '0;
        case (EDGE_MODE)
            0:       hit = filt & ~filt_d;
            1:       hit = ~filt & filt_d;
            default: hit = filt ^ filt_d;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux[WIDTH-1:0] = filt;
            3'd2:    rd_mux[WIDTH-1:0] = irqmask;
            3'd3:    rd_mux[WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d      <= '1;
            irqmask     <= '0;
            edgecapture <= '0;
            irq         <= 1'b0;
            readdata    <= '0;
        end else begin
            filt_d <= filt;
            if (wr && address == 3'd2)
                irqmask <= writedata[WIDTH-1:0];
            // OR-ing hit after the clear lets a same-cycle edge win.
            edgecapture <= (edgecapture & ~clr) | hit;
            irq         <= |(edgecapture & irqmask);
            readdata    <= rd_mux;
        end
    end

endmodule

// File: tb/tb_key_pio_edge.sv
module tb_key_pio_edge;

    localparam int W = 8;
`ifdef KEY_PIO_DEBOUNCE_EN
    localparam bit DB = 1'b1;
    localparam int FILT_LAT = 18;  // 2 sync + 16 debounce
`else
    localparam bit DB = 1'b0;
    localparam int FILT_LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [W-1:0] in1, in2;
    logic [31:0]  rd1, rd2;
    logic         irq1, irq2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_pio_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(16), .EDGE_MODE(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(rd1), .irq(irq1)
    );

    key_pio_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(16), .EDGE_MODE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(rd2), .irq(irq2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v1, output logic [31:0] v2);
        address = a;
        tick();
        v1 = rd1; v2 = rd2;
    endtask

    task automatic test_reset();
        logic [31:0] v1, v2;
        reset_n = 1'b0; in1 = '1; in2 = '1; address = 3'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        #1;
        checks++; if (rd1 !== 32'h0 || irq1 !== 1'b0) begin errors++;
            $display("FAIL reset_hold: readdata=%h irq=%b want 0/0", rd1, irq1); end
        repeat (3) tick();
        reset_n = 1'b1;
        rd(3'd0, v1, v2);
        checks++; if (v1 !== 32'h0000_00FF) begin errors++;
            $display("FAIL reset_data: got %h want 000000ff", v1); end
        checks++; if (irq1 !== 1'b0) begin errors++;
            $display("FAIL reset_irq: got %b want 0", irq1); end
        rd(3'd3, v1, v2);
        checks++; if (v1 !== 32'h0) begin errors++;
            $display("FAIL reset_ec: got %h want 0", v1); end
        wr(3'd1, 32'hFFFF_FFFF);
        rd(3'd1, v1, v2);
        checks++; if (v1 !== 32'h0) begin errors++;
            $display("FAIL unused_addr: got %h want 0", v1); end
    endtask

    task automatic test_debounce();
        logic [31:0] v1, v2;
        in1[0] = 1'b0;
        repeat (10) tick();
        in1[0] = 1'b1;
        repeat (25) tick();
        rd(3'd0, v1, v2);
        checks++; if (v1 !== 32'hFF) begin errors++;
            $display("FAIL short_pulse_data: got %h want ff", v1); end
        rd(3'd3, v1, v2);
        checks++; if (v1 !== (DB ? 32'h0 : 32'h1)) begin errors++;
            $display("FAIL short_pulse_ec: got %h want %h", v1, DB ? 32'h0 : 32'h1); end
        wr(3'd3, 32'hFF);
        in1[0] = 1'b0;
        repeat (20) tick();
        rd(3'd0, v1, v2);
        checks++; if (v1 !== 32'hFE) begin errors++;
            $display("FAIL long_press_data: got %h want fe", v1); end
        rd(3'd3, v1, v2);
        checks++; if (v1 !== 32'h01) begin errors++;
            $display("FAIL long_press_ec: got %h want 01", v1); end
    endtask

    task automatic test_irq();
        logic [31:0] v1, v2;
        wr(3'd2, 32'h01);
        checks++; if (irq1 !== 1'b0) begin errors++;
            $display("FAIL irq_early: got %b want 0", irq1); end
        tick();
        checks++; if (irq1 !== 1'b1) begin errors++;
            $display("FAIL irq_rise: got %b want 1", irq1); end
        wr(3'd3, 32'h01);
        tick();
        checks++; if (irq1 !== 1'b0) begin errors++;
            $display("FAIL irq_clear: got %b want 0", irq1); end
        rd(3'd3, v1, v2);
        checks++; if (v1 !== 32'h0) begin errors++;
            $display("FAIL ec_clear: got %h want 0", v1); end
        // rising edge is ignored in falling mode; the next fall sets it again
        in1[0] = 1'b1;
        repeat (FILT_LAT + 4) tick();
        checks++; if (irq1 !== 1'b0) begin errors++;
            $display("FAIL rise_ignored_irq: got %b want 0", irq1); end
        in1[0] = 1'b0;
        repeat (FILT_LAT + 4) tick();
        checks++; if (irq1 !== 1'b1) begin errors++;
            $display("FAIL irq_refire: got %b want 1", irq1); end
        wr(3'd2, 32'h0);
        tick();
        checks++; if (irq1 !== 1'b0) begin errors++;
            $display("FAIL irq_masked: got %b want 0", irq1); end
        wr(3'd2, 32'hFFFF_FF00);
        rd(3'd2, v1, v2);
        checks++; if (v1 !== 32'h0) begin errors++;
            $display("FAIL mask_upper_bits: got %h want 0", v1); end
        wr(3'd2, 32'h0);
        wr(3'd3, 32'hFF);
        in1[0] = 1'b1;
        repeat (FILT_LAT + 4) tick();
    endtask

    task automatic test_set_clear_collision();
        logic [31:0] v1, v2;
        in1[2] = 1'b0;
        repeat (FILT_LAT) tick();
        wr(3'd3, 32'h04);   // lands on the same edge the capture sets
        rd(3'd3, v1, v2);
        checks++; if (v1 !== 32'h04) begin errors++;
            $display("FAIL set_wins: got %h want 04", v1); end
        wr(3'd3, 32'h04);
        rd(3'd3, v1, v2);
        checks++; if (v1 !== 32'h0) begin errors++;
            $display("FAIL plain_clear: got %h want 0", v1); end
    endtask

    task automatic test_any_edge();
        logic [31:0] v1, v2;
        address = 3'd3;
        in2[7] = 1'b0;
        repeat (FILT_LAT + 1) tick();
        checks++; if (rd2 !== 32'h0) begin errors++;
            $display("FAIL any_fall_early: got %h want 0", rd2); end
        tick();
        checks++; if (rd2 !== 32'h80) begin errors++;
            $display("FAIL any_fall: got %h want 80", rd2); end
        wr(3'd3, 32'h80);
        rd(3'd3, v1, v2);
        checks++; if (v2 !== 32'h0) begin errors++;
            $display("FAIL any_clear: got %h want 0", v2); end
        in2[7] = 1'b1;
        repeat (FILT_LAT + 1) tick();
        checks++; if (rd2 !== 32'h0) begin errors++;
            $display("FAIL any_rise_early: got %h want 0", rd2); end
        tick();
        checks++; if (rd2 !== 32'h80) begin errors++;
            $display("FAIL any_rise: got %h want 80", rd2); end
        wr(3'd3, 32'h80);
    endtask

    task automatic test_reset_pulse();
        logic [31:0] v1, v2;
        in1 = '1;
        repeat (FILT_LAT + 4) tick();
        wr(3'd3, 32'hFF);
        in1 = 8'hC3;
        repeat (FILT_LAT + 4) tick();
        wr(3'd2, 32'h3C);
        tick();
        checks++; if (irq1 !== 1'b1) begin errors++;
            $display("FAIL pre_reset_irq: got %b want 1", irq1); end
        rd(3'd3, v1, v2);
        checks++; if (v1 !== 32'h3C) begin errors++;
            $display("FAIL pre_reset_ec: got %h want 3c", v1); end
        reset_n = 1'b0;
        #1;
        checks++; if (rd1 !== 32'h0 || irq1 !== 1'b0) begin errors++;
            $display("FAIL async_reset: readdata=%h irq=%b want 0/0", rd1, irq1); end
        in1 = '1;
        repeat (3) tick();
        checks++; if (rd1 !== 32'h0 || irq1 !== 1'b0) begin errors++;
            $display("FAIL reset_held: readdata=%h irq=%b want 0/0", rd1, irq1); end
        reset_n = 1'b1;
        repeat (FILT_LAT + 4) tick();
        rd(3'd3, v1, v2);
        checks++; if (v1 !== 32'h0) begin errors++;
            $display("FAIL post_reset_ec: got %h want 0", v1); end
        rd(3'd2, v1, v2);
        checks++; if (v1 !== 32'h0) begin errors++;
            $display("FAIL post_reset_mask: got %h want 0", v1); end
        rd(3'd0, v1, v2);
        checks++; if (v1 !== 32'hFF || irq1 !== 1'b0) begin errors++;
            $display("FAIL post_reset_data: data=%h irq=%b want ff/0", v1, irq1); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_irq();
        test_set_clear_collision();
        test_any_edge();
        test_reset_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_pio_edge.md
KEY_PIO_EDGE -- requirements
Module: key_pio_edge

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of input bits (legal 1..32).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 50000, clk cycles an input must hold stable before acceptance (legal 2..2^20).
REQ-003 SHALL provide parameter EDGE_MODE, default 1, edge capture type: 0 = rising, 1 = falling, 2 = any.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select; qualifies write.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  raw asynchronous key inputs.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  level interrupt, active-high.

Function
REQ-013 SHALL pass each in_port bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL map registers: addr 0 = data (RO, filtered inputs); addr 2 = irqmask (RW, WIDTH bits); addr 3 = edgecapture (RO, write-1-to-clear); all other addresses read 0, writes ignored.
REQ-015 readdata SHALL be updated on every clock with the addressed register, zero-extended to 32 bits, giving one-cycle read latency independent of chipselect.
REQ-016 A write occurs when chipselect=1 and write_n=0; the addressed register updates on that clock edge.
REQ-017 Per bit, edgecapture SHALL set on the cycle after the filtered value changes in the direction selected by EDGE_MODE.
REQ-018 A write to addr 3 SHALL clear each edgecapture bit whose writedata bit is 1; when a set and a clear coincide on the same bit, set SHALL win.
REQ-019 irq SHALL be registered and equal OR over (edgecapture AND irqmask), asserting one cycle after the contributing term goes non-zero.
REQ-020 Writing irqmask with edgecapture already set SHALL raise irq on the following cycle; masking it SHALL drop irq on the following cycle.
REQ-021 writedata bits above WIDTH-1 SHALL be ignored; unused readdata bits SHALL read 0.

Reset
REQ-022 On reset_n low, readdata, irqmask, edgecapture and irq SHALL be 0 immediately, asynchronously.
REQ-023 On reset, synchronizer and filtered registers SHALL be loaded to all-ones (keys idle high), and debounce counters SHALL be 0.
REQ-024 Reset asserted mid-debounce SHALL discard the pending change with no edge recorded.

Configuration
REQ-025 Macro KEY_PIO_DEBOUNCE_EN: when defined, each bit SHALL have a counter; the filtered bit updates only after the synchronized bit differs from it for DEBOUNCE_CYCLES consecutive cycles, and any reversion resets the counter to 0.
REQ-026 When KEY_PIO_DEBOUNCE_EN is undefined, the filtered value SHALL equal the synchronizer output, DEBOUNCE_CYCLES SHALL be ignored, and no counters SHALL be synthesized.

Verification
REQ-027 Reset release, WIDTH=8, in_port=8'hFF, read addr 0 -> readdata=32'h000000FF one cycle after the address is presented; irq=0.
REQ-028 DEBOUNCE_EN, DEBOUNCE_CYCLES=16, bit0 driven low for 10 cycles, then high -> data bit0 stays 1, edgecapture=0; driven low for 20 cycles -> data=8'hFE, edgecapture=8'h01.
REQ-029 edgecapture=8'h01, write irqmask=8'h01 -> irq=1 the following cycle; write addr 3 with 8'h01 -> edgecapture=0, irq=0 one cycle later.
REQ-030 A falling edge on bit2 coinciding with a write of 8'h04 to addr 3 -> edgecapture bit2 remains 1.
REQ-031 EDGE_MODE=2, no DEBOUNCE_EN, bit7 toggles low then high with a clear between -> edgecapture bit7 is set on both edges, with sync-path latency of 3 cycles.
REQ-032 Reset pulsed with edgecapture=8'h3C and irq=1 -> all registers read 0 and irq=0 while reset_n is low, with no spurious edge after release.
